// File: rtl/rv_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline; optional perf counters under HAZARD_PERF_CNT_EN.
// Latency: FWD_* registered as the instruction enters EX; STALL_*/BUBBLE and the first FLUSH cycle are combinational.
// Backpressure: BUSYWAIT freezes every flop; outputs derived from state hold until it drops.
module rv_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              BUSYWAIT,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic [REG_AW-1:0] ID_RD,
    input  logic              ID_USES_RS1,
    input  logic              ID_USES_RS2,
    input  logic              ID_REG_WRITE,
    input  logic              ID_MEM_READ,
    input  logic              BRANCH_TAKEN,
    output logic [1:0]        FWD_A,
    output logic [1:0]        FWD_B,
    output logic              STALL_PC,
    output logic              STALL_IF_ID,
    output logic              BUBBLE_ID_EX,
    output logic              FLUSH,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [CNT_W-1:0]  FLUSH_CNT
);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              load;
    } sb_entry_t;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_FLUSHING = 1'b1;
    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);

    sb_entry_t   ex_q, mem_q, wb_q, id_req;
    logic [0:0]  state_q;
    logic [2:0]  flush_cnt_q;
    logic [1:0]  fwd_a_q, fwd_b_q, fwd_a_nxt, fwd_b_nxt;
    logic        use_a, use_b, ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic        flush_trig, flush, stall;

    always_comb begin
        id_req.vld  = ID_REG_WRITE && (ID_RD != '0);
        id_req.rd   = ID_RD;
        id_req.load = ID_MEM_READ;
    end

    assign use_a     = ID_USES_RS1 && (ID_RS1 != '0);
    assign use_b     = ID_USES_RS2 && (ID_RS2 != '0);
    assign ex_hit_a  = use_a && ex_q.vld && (ex_q.rd == ID_RS1);
    assign ex_hit_b  = use_b && ex_q.vld && (ex_q.rd == ID_RS2);
    assign mem_hit_a = use_a && mem_q.vld && (mem_q.rd == ID_RS1);
    assign mem_hit_b = use_b && mem_q.vld && (mem_q.rd == ID_RS2);

    // Youngest producer wins; WB needs no path because the regfile writes before it reads.
    assign fwd_a_nxt = ex_hit_a ? 2'b01 : (mem_hit_a ? 2'b10 : 2'b00);
    assign fwd_b_nxt = ex_hit_b ? 2'b01 : (mem_hit_b ? 2'b10 : 2'b00);

    // A branch arriving during FLUSHING belongs to a squashed instruction, so only IDLE can trigger.
    assign flush_trig = (state_q == ST_IDLE) && BRANCH_TAKEN && !BUSYWAIT;
    assign flush      = (state_q == ST_FLUSHING) || flush_trig;
    assign stall      = ex_q.load && (ex_hit_a || ex_hit_b) && !flush;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            state_q     <= ST_IDLE;
            flush_cnt_q <= 3'd0;
        end else if (!BUSYWAIT) begin
            wb_q    <= mem_q;
            mem_q   <= flush ? '0 : ex_q;
            ex_q    <= (flush || stall) ? '0 : id_req;
            fwd_a_q <= (flush || stall) ? 2'b00 : fwd_a_nxt;
            fwd_b_q <= (flush || stall) ? 2'b00 : fwd_b_nxt;
            case (state_q)
                ST_IDLE: begin
                    if (BRANCH_TAKEN && (FLUSH_CYCLES > 1)) begin
                        state_q     <= ST_FLUSHING;
                        flush_cnt_q <= FLUSH_LOAD;
                    end
                end
                default: begin
                    flush_cnt_q <= flush_cnt_q - 3'd1;
                    if (flush_cnt_q == 3'd1) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign FWD_A        = fwd_a_q;
    assign FWD_B        = fwd_b_q;
    assign STALL_PC     = stall;
    assign STALL_IF_ID  = stall;
    assign BUBBLE_ID_EX = stall;
    assign FLUSH        = flush;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_evt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            flush_evt_q <= '0;
        end else if (!BUSYWAIT) begin
            if (stall)      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_trig) flush_evt_q <= flush_evt_q + CNT_W'(1);
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_evt_q;
`else
    assign STALL_CNT = '0;
    assign FLUSH_CNT = '0;
`endif

    // The WB entry and the MEM load bit are tracked for pipeline fidelity but feed no compare.
    logic unused_sb;
    assign unused_sb = ^{wb_q, mem_q.load};

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Directed table-driven bench for rv_hazard_ctrl plus short hand-written corner sequences.
module tb_rv_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, busywait, uses1, uses2, regw, memr, br;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall_pc, stall_if_id, bubble, flush;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    rv_hazard_ctrl dut (
        .CLK(clk), .RESET(reset), .BUSYWAIT(busywait),
        .ID_RS1(rs1), .ID_RS2(rs2), .ID_RD(rd),
        .ID_USES_RS1(uses1), .ID_USES_RS2(uses2),
        .ID_REG_WRITE(regw), .ID_MEM_READ(memr), .BRANCH_TAKEN(br),
        .FWD_A(fwd_a), .FWD_B(fwd_b),
        .STALL_PC(stall_pc), .STALL_IF_ID(stall_if_id), .BUBBLE_ID_EX(bubble),
        .FLUSH(flush), .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
    );

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, rw, mr, br, bw, rst;
        logic [1:0] ea, eb;
        logic       es, ef, cc;
        int         sc, fc;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [4:0] a, b, d,
                                input logic u1, u2, rw, mr, br, bw, rst,
                                input logic [1:0] ea, eb, input logic es, ef, cc,
                                input int sc, fc);
        vec_t v;
        v.rs1 = a; v.rs2 = b; v.rd = d;
        v.u1 = u1; v.u2 = u2; v.rw = rw; v.mr = mr; v.br = br; v.bw = bw; v.rst = rst;
        v.ea = ea; v.eb = eb; v.es = es; v.ef = ef; v.cc = cc; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h, expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
        uses1 = v.u1; uses2 = v.u2; regw = v.rw; memr = v.mr;
        br = v.br; busywait = v.bw; reset = v.rst;
    endtask

    task automatic check_row(input int i, input vec_t v);
        chk("fwd_a", i, 32'(fwd_a), 32'(v.ea));
        chk("fwd_b", i, 32'(fwd_b), 32'(v.eb));
        chk("stall_pc", i, 32'(stall_pc), 32'(v.es));
        chk("stall_if_id", i, 32'(stall_if_id), 32'(v.es));
        chk("bubble", i, 32'(bubble), 32'(v.es));
        chk("flush", i, 32'(flush), 32'(v.ef));
        if (v.cc) begin
            chk("stall_cnt", i, stall_cnt, PERF ? 32'(v.sc) : 32'd0);
            chk("flush_cnt", i, flush_cnt, PERF ? 32'(v.fc) : 32'd0);
        end
    endtask

    task automatic step(input int i, input vec_t v);
        drive(v);
        @(negedge clk);
        check_row(i, v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t nop, v;
        nop = mk(0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0, 0,0);
        //              rs1 rs2 rd  u1 u2 rw mr br bw rst  ea eb es ef cc sc fc
        tbl.push_back(mk( 1,  2,  5, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0)); // 0 add x5
        tbl.push_back(mk( 5,  3,  6, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 1 sub x6,x5,x3
        tbl.push_back(mk( 0,  0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0)); // 2 sub in EX: A=01
        tbl.push_back(nop);                                                       // 3
        tbl.push_back(mk( 1,  2,  5, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 4 add x5
        tbl.push_back(nop);                                                       // 5 nop
        tbl.push_back(mk( 0,  5,  7, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 6 or x7,x0,x5
        tbl.push_back(mk( 0,  0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0)); // 7 or in EX: B=10
        tbl.push_back(mk( 1,  0,  0, 1, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 8 lw x0
        tbl.push_back(mk( 0,  0,  8, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 9 add x8,x0,x0: no stall
        tbl.push_back(mk( 1,  0,  5, 1, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 10 lw x5
        tbl.push_back(mk( 5,  5,  6, 1, 1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0)); // 11 load-use stall
        tbl.push_back(mk( 5,  5,  6, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 12 replay, bubble in EX
        tbl.push_back(mk( 0,  0,  0, 0, 0, 0, 0, 0, 0, 0,  2, 2, 0, 0, 1, 1, 0)); // 13 A=B=10
        tbl.push_back(mk( 1,  0,  9, 1, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 14 lw x9
        tbl.push_back(mk( 9,  0, 10, 1, 1, 1, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0)); // 15 branch + load-use
        tbl.push_back(mk(10,  9, 11, 1, 1, 1, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0)); // 16 2nd branch ignored
        tbl.push_back(mk( 0,  0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1)); // 17 flush over
        tbl.push_back(mk( 1,  0, 12, 1, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 18 lw x12
        tbl.push_back(mk(12,  2, 13, 1, 1, 1, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0)); // 19 stall, busy
        tbl.push_back(mk(12,  2, 13, 1, 1, 1, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0)); // 20
        tbl.push_back(mk(12,  2, 13, 1, 1, 1, 0, 0, 1, 0,  0, 0, 1, 0, 1, 1, 1)); // 21 counters frozen
        tbl.push_back(mk(12,  2, 13, 1, 1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0)); // 22 stall completes
        tbl.push_back(mk(12,  2, 13, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // 23
        tbl.push_back(mk( 0,  0,  0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 1, 2, 1)); // 24 A=10
        tbl.push_back(mk( 0,  0,  0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0)); // 25 branch while busy
        tbl.push_back(mk( 0,  0,  0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0)); // 26 busy drops: flush
        tbl.push_back(mk( 0,  0,  0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 2, 2)); // 27 reset mid-flush
        tbl.push_back(mk( 0,  0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0)); // 28 all cleared

        drive(nop);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

        // Reset asserted in a load-use stall cycle aborts the stall.
        step(100, mk(1, 0, 5, 1, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        step(101, mk(5, 0, 6, 1, 0, 1, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0, 0));
        step(102, mk(5, 0, 6, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0));

        // Two in-flight producers of x5: the EX one wins.
        step(110, mk(1, 2, 5, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        step(111, mk(3, 4, 5, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        step(112, mk(5, 5, 6, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        v = nop;
        v.ea = 2'b01; v.eb = 2'b01;
        step(113, v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
